// File: rtl/fifo_checker.sv
// Passive single-clock FIFO checker: keeps its own occupancy and shadow memory,
// cross-checks the DUT flags and read data, and counts transactions.
module fifo_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      Wr_enable,
  input  logic                      Read_enable,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [DATA_W-1:0]         data_out,
  input  logic                      full,
  input  logic                      empty,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          wr_count,
  output logic [CNT_W-1:0]          rd_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic [3:0]                err_flag,
  output logic [DATA_W/8-1:0]       err_lane,
  output logic                      error,
  output logic [2:0]                first_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int NL = DATA_W / 8;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              armed;
  logic              ill_pend;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_word;

  logic              model_full;
  logic              model_empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              drop;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_word;
  logic [NL-1:0]     lane_mis;
  logic [3:0]        new_err;
  logic [2:0]        new_code;

  // With RD_LAT=1 the comparison uses the head word captured at the accepting edge.
  always_comb begin
    model_full  = (occupancy == FULL_OCC);
    model_empty = (occupancy == '0);
    wr_acc      = Wr_enable && !model_full;
    rd_acc      = Read_enable && !model_empty;
    drop        = (Wr_enable && model_full) || (Read_enable && model_empty);
    cmp_valid   = (RD_LAT == 0) ? rd_acc : exp_valid;
    cmp_word    = (RD_LAT == 0) ? mem[rd_ptr] : exp_word;
    lane_mis    = '0;
    for (int i = 0; i < NL; i++) begin
      lane_mis[i] = armed && cmp_valid && (data_out[8*i +: 8] != cmp_word[8*i +: 8]);
    end
    new_err[0] = armed && (full != model_full);
    new_err[1] = armed && (empty != model_empty);
    new_err[2] = |lane_mis;
    new_err[3] = armed && ill_pend && !full;
    new_code   = 3'd0;
    if (new_err[0])      new_code = 3'd1;
    else if (new_err[1]) new_code = 3'd2;
    else if (new_err[2]) new_code = 3'd3;
    else if (new_err[3]) new_code = 3'd4;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      armed     <= 1'b0;
      ill_pend  <= 1'b0;
      exp_valid <= 1'b0;
      exp_word  <= '0;
    end else begin
      armed     <= 1'b1;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + OW'(wr_acc) - OW'(rd_acc);
      ill_pend  <= model_full && Wr_enable && !Read_enable;
      exp_valid <= rd_acc;
      if (rd_acc) exp_word <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count   <= '0;
      rd_count   <= '0;
      drop_count <= '0;
    end else if (clear) begin
      wr_count   <= '0;
      rd_count   <= '0;
      drop_count <= '0;
    end else begin
      if (wr_acc && wr_count != '1)   wr_count   <= wr_count + CNT_W'(1);
      if (rd_acc && rd_count != '1)   rd_count   <= rd_count + CNT_W'(1);
      if (drop && drop_count != '1)   drop_count <= drop_count + CNT_W'(1);
    end
  end

  // Errors detected at a clearing edge are deliberately dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flag  <= '0;
      err_lane  <= '0;
      first_err <= '0;
    end else if (clear) begin
      err_flag  <= '0;
      err_lane  <= '0;
      first_err <= '0;
    end else begin
      err_flag <= err_flag | new_err;
      err_lane <= err_lane | lane_mis;
      if (first_err == 3'd0 && new_err != 4'd0) first_err <= new_code;
    end
  end

  assign error = |err_flag;

endmodule

// File: tb/tb_fifo_checker.sv
// Bench for fifo_checker: emulates a FIFO DUT with a queue, drives two checker
// instances (RD_LAT=0/CNT_W=16 and RD_LAT=1/CNT_W=4) and predicts their outputs.
module tb_fifo_checker;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic [31:0] data_in = '0;
  logic [31:0] data_out0 = '0;
  logic [31:0] data_out1 = '0;

  logic [4:0]  occ0, occ1;
  logic [15:0] wr_cnt0, rd_cnt0, drop_cnt0;
  logic [3:0]  wr_cnt1, rd_cnt1, drop_cnt1;
  logic [3:0]  err0, err1, lane0, lane1;
  logic        error0, error1;
  logic [2:0]  first0, first1;

  fifo_checker #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .Wr_enable(wr_en), .Read_enable(rd_en),
    .data_in(data_in), .data_out(data_out0), .full(full), .empty(empty),
    .occupancy(occ0), .wr_count(wr_cnt0), .rd_count(rd_cnt0), .drop_count(drop_cnt0),
    .err_flag(err0), .err_lane(lane0), .error(error0), .first_err(first0));

  fifo_checker #(.DATA_W(32), .DEPTH(DEPTH), .RD_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .Wr_enable(wr_en), .Read_enable(rd_en),
    .data_in(data_in), .data_out(data_out1), .full(full), .empty(empty),
    .occupancy(occ1), .wr_count(wr_cnt1), .rd_count(rd_cnt1), .drop_count(drop_cnt1),
    .err_flag(err1), .err_lane(lane1), .error(error1), .first_err(first1));

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, raw event counts, expected sticky state.
  logic [31:0] q[$];
  int          n_wr, n_rd, n_drop;
  logic [3:0]  m_err0, m_err1, m_lane0, m_lane1;
  logic [2:0]  m_first0, m_first1;
  logic        armed_m, ill_m, pend_valid;
  logic [31:0] pend_exp, pend_drv;
  logic        full_force_en, full_force_val, empty_force_en, empty_force_val;
  logic [31:0] corrupt;
  int          errors = 0;
  int          checks = 0;

  function automatic int sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  function automatic logic [3:0] lane_diff(input logic [31:0] a, input logic [31:0] b);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = (a[8*i +: 8] != b[8*i +: 8]);
    return m;
  endfunction

  function automatic logic [2:0] code_of(input logic [3:0] e);
    if (e[0]) return 3'd1;
    if (e[1]) return 3'd2;
    if (e[2]) return 3'd3;
    if (e[3]) return 3'd4;
    return 3'd0;
  endfunction

  // One clock: drive from the emulated DUT, predict checker results, advance the model.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic clr);
    int          sz;
    logic        fm, em, wa, ra;
    logic [31:0] head;
    logic [3:0]  l0, l1, e0, e1;
    sz = q.size();
    fm = (sz == DEPTH);
    em = (sz == 0);
    wa = w && !fm;
    ra = r && !em;
    head = 32'h0;
    if (ra) head = q[0];
    wr_en = w; rd_en = r; data_in = d; clear = clr;
    full  = full_force_en ? full_force_val : fm;
    empty = empty_force_en ? empty_force_val : em;
    data_out0 = ra ? (head ^ corrupt) : $urandom;
    data_out1 = pend_valid ? pend_drv : $urandom;
    l0 = '0; l1 = '0; e0 = '0;
    if (armed_m) begin
      if (ra) l0 = lane_diff(data_out0, head);
      if (pend_valid) l1 = lane_diff(data_out1, pend_exp);
      e0[0] = (full != fm);
      e0[1] = (empty != em);
      e0[3] = ill_m && !full;
    end
    e1 = e0;
    e0[2] = |l0;
    e1[2] = |l1;
    @(posedge clk);
    if (clr) begin
      m_err0 = '0; m_err1 = '0; m_lane0 = '0; m_lane1 = '0; m_first0 = '0; m_first1 = '0;
      n_wr = 0; n_rd = 0; n_drop = 0;
    end else begin
      if (m_first0 == 3'd0 && e0 != 4'd0) m_first0 = code_of(e0);
      if (m_first1 == 3'd0 && e1 != 4'd0) m_first1 = code_of(e1);
      m_err0 |= e0; m_err1 |= e1; m_lane0 |= l0; m_lane1 |= l1;
      n_wr += int'(wa);
      n_rd += int'(ra);
      n_drop += int'((w && !wa) || (r && !ra));
    end
    ill_m = fm && w && !r;
    pend_valid = ra;
    pend_exp = head;
    pend_drv = head ^ corrupt;
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    armed_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0; full = 1'b0; empty = 1'b1;
    full_force_en = 1'b0; full_force_val = 1'b0;
    empty_force_en = 1'b0; empty_force_val = 1'b0;
    corrupt = '0;
    q.delete();
    n_wr = 0; n_rd = 0; n_drop = 0;
    m_err0 = '0; m_err1 = '0; m_lane0 = '0; m_lane1 = '0; m_first0 = '0; m_first1 = '0;
    armed_m = 1'b0; ill_m = 1'b0; pend_valid = 1'b0; pend_exp = '0; pend_drv = '0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    apply_reset();
    checks++;
    if ({occ0, wr_cnt0, rd_cnt0, drop_cnt0, err0, lane0, first0, error0} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut0: got %h required 0",
               {occ0, wr_cnt0, rd_cnt0, drop_cnt0, err0, lane0, first0, error0});
    end
    checks++;
    if ({occ1, wr_cnt1, rd_cnt1, drop_cnt1, err1, lane1, first1, error1} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut1: got %h required 0",
               {occ1, wr_cnt1, rd_cnt1, drop_cnt1, err1, lane1, first1, error1});
    end
    release_reset();
    full_force_en = 1'b1; full_force_val = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    full_force_en = 1'b0;
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL first_cycle_suppressed: got %b required 00", {error0, error1});
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (err0 !== m_err0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h required %h", err0, m_err0);
    end
  endtask

  task automatic test_fill_drain();
    for (int n = 0; n < DEPTH; n++) step(1'b1, 1'b0, 32'h01020304 + 32'(n), 1'b0);
    checks++;
    if (occ0 !== 5'd16 || occ1 !== 5'd16) begin
      errors++;
      $display("[TB] FAIL fill_peak: got %0d/%0d required 16", occ0, occ1);
    end
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (wr_cnt0 !== 16'd16 || rd_cnt0 !== 16'd16 || occ0 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL drain_counts: got wr=%0d rd=%0d occ=%0d required 16 16 0",
               wr_cnt0, rd_cnt0, occ0);
    end
    checks++;
    if (wr_cnt1 !== 4'(sat(n_wr, 4)) || rd_cnt1 !== 4'd15) begin
      errors++;
      $display("[TB] FAIL saturate_cnt4: got wr=%0d rd=%0d required %0d 15",
               wr_cnt1, rd_cnt1, sat(n_wr, 4));
    end
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fill_drain_error: got %b required 00", {error0, error1});
    end
  endtask

  task automatic test_overflow_underflow();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < DEPTH; n++) step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    checks++;
    if (occ0 !== 5'd16 || drop_cnt0 !== 16'd1) begin
      errors++;
      $display("[TB] FAIL overflow: got occ=%0d drop=%0d required 16 1", occ0, drop_cnt0);
    end
    for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0);
    checks++;
    if (occ0 !== 5'd0 || drop_cnt0 !== 16'd2 || drop_cnt1 !== 4'(sat(n_drop, 4))) begin
      errors++;
      $display("[TB] FAIL underflow: got occ=%0d drop=%0d/%0d required 0 2 %0d",
               occ0, drop_cnt0, drop_cnt1, n_drop);
    end
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL over_under_error: got %b required 00", {error0, error1});
    end
  endtask

  task automatic test_data_corruption();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0);
    corrupt = 32'h00FF0000;
    step(1'b0, 1'b1, 32'h0, 1'b0);
    corrupt = '0;
    checks++;
    if (lane0 !== 4'b0100 || err0[2] !== 1'b1 || first0 !== 3'd3) begin
      errors++;
      $display("[TB] FAIL corrupt_lat0: got lane=%b err=%b first=%0d required 0100 x1xx 3",
               lane0, err0, first0);
    end
    checks++;
    if (err1[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL corrupt_lat1_early: got err=%b required bit2=0", err1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (lane1 !== 4'b0100 || err1 !== m_err1 || first1 !== 3'd3) begin
      errors++;
      $display("[TB] FAIL corrupt_lat1: got lane=%b err=%b first=%0d required 0100 %b 3",
               lane1, err1, first1, m_err1);
    end
    step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_flag_fault();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h12345678, 1'b0);
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL flag_pre: got %b required 00", {error0, error1});
    end
    empty_force_en = 1'b1; empty_force_val = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    empty_force_en = 1'b0;
    checks++;
    if (err0 !== 4'b0010 || first0 !== 3'd2 || err1 !== 4'b0010 || first1 !== 3'd2) begin
      errors++;
      $display("[TB] FAIL empty_fault: got err=%b/%b first=%0d/%0d required 0010 2",
               err0, err1, first0, first1);
    end
    step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int rd_before, drop_before;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, $urandom, 1'b0);
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b1, $urandom, 1'b0);
      checks++;
      if (occ0 !== 5'd8 || occ1 !== 5'd8) begin
        errors++;
        $display("[TB] FAIL rw_occ cycle %0d: got %0d/%0d required 8", n, occ0, occ1);
      end
    end
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, $urandom, 1'b0);
    rd_before = n_rd;
    drop_before = n_drop;
    step(1'b1, 1'b1, $urandom, 1'b0);
    checks++;
    if (rd_cnt0 !== 16'(rd_before + 1) || drop_cnt0 !== 16'(drop_before + 1) || occ0 !== 5'd15) begin
      errors++;
      $display("[TB] FAIL rw_at_full: got rd=%0d drop=%0d occ=%0d required %0d %0d 15",
               rd_cnt0, drop_cnt0, occ0, rd_before + 1, drop_before + 1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rw_error: got %b required 00", {error0, error1});
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, $urandom, 1'b0);
    step(1'b1, 1'b0, $urandom, 1'b0);
    full_force_en = 1'b1; full_force_val = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    full_force_en = 1'b0;
    checks++;
    if (err0 !== 4'b1001 || first0 !== 3'd1 || err1 !== 4'b1001 || first1 !== 3'd1) begin
      errors++;
      $display("[TB] FAIL illegal_write: got err=%b/%b first=%0d/%0d required 1001 1",
               err0, err1, first0, first1);
    end
  endtask

  task automatic test_clear();
    empty_force_en = 1'b1; empty_force_val = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    empty_force_en = 1'b0;
    checks++;
    if ({error0, err0, first0, error1, err1, first1} !== 16'd0 || occ0 !== 5'd16) begin
      errors++;
      $display("[TB] FAIL clear: got err=%b/%b first=%0d/%0d occ=%0d required 0 0 16",
               err0, err1, first0, first1, occ0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({error0, error1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL after_clear: got %b required 00", {error0, error1});
    end
  endtask

  task automatic test_reset_midstream();
    for (int n = 0; n < 11; n++) step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (occ0 !== 5'd5) begin
      errors++;
      $display("[TB] FAIL mid_occ: got %0d required 5", occ0);
    end
    apply_reset();
    checks++;
    if ({occ0, wr_cnt0, rd_cnt0, drop_cnt0, err0, lane0, first0, error0} !== 65'd0 ||
        {occ1, wr_cnt1, rd_cnt1, drop_cnt1, err1, lane1, first1, error1} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got occ=%0d/%0d wr=%0d rd=%0d required all 0",
               occ0, occ1, wr_cnt0, rd_cnt0);
    end
    release_reset();
  endtask

  task automatic test_random();
    logic [63:0] got0, want0;
    logic [27:0] got1, want1;
    int bias;
    for (int i = 0; i < 400; i++) begin
      bias = (((i / 50) % 2) == 0) ? 70 : 30;
      corrupt = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'h0;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias), $urandom,
           $urandom_range(0, 49) == 0);
      corrupt = '0;
      got0  = {occ0, wr_cnt0, rd_cnt0, drop_cnt0, err0, lane0, first0};
      want0 = {5'(q.size()), 16'(sat(n_wr, 16)), 16'(sat(n_rd, 16)), 16'(sat(n_drop, 16)),
               m_err0, m_lane0, m_first0};
      got1  = {occ1, wr_cnt1, rd_cnt1, drop_cnt1, err1, lane1, first1};
      want1 = {5'(q.size()), 4'(sat(n_wr, 4)), 4'(sat(n_rd, 4)), 4'(sat(n_drop, 4)),
               m_err1, m_lane1, m_first1};
      checks++;
      if (got0 !== want0) begin
        errors++;
        $display("[TB] FAIL rand_dut0 cycle %0d: got %h required %h", i, got0, want0);
      end
      checks++;
      if (got1 !== want1) begin
        errors++;
        $display("[TB] FAIL rand_dut1 cycle %0d: got %h required %h", i, got1, want1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_data_corruption();
    test_flag_fault();
    test_back_to_back();
    test_illegal();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
